cordic_sched: RTL
=================

# cordic_sched

Round-robin scheduler that time-shares one `cordic_calc` vectoring unit among `NCH` hydrophone phase channels. Each channel presents an I/Q sample (6Q10) with a level request. The block grants one channel at a time, latches its operands, and drives `start`/`enable` on the CORDIC for exactly `NITER` iterations. It then returns modulus (6Q10) and angle (9Q7) tagged with the channel index. It sits between the per-channel demodulators and the direction-of-arrival logic.

## Interface
- `NCH`, 4, number of requesting channels (2..8)
- `NITER`, 16, CORDIC iterations per conversion; must match the iteration counter length
- `CHW`, 2, width of channel index; must equal clog2(`NCH`)
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `req`  in  NCH  level request per channel
- `x_in`  in  16*NCH  signed X per channel, channel k at [16k+15:16k]
- `y_in`  in  16*NCH  signed Y per channel, same packing
- `ack`  out  NCH  one-cycle pulse; operands of that channel captured
- `cordic_start`  out  1  to `cordic_calc.start`
- `cordic_enable`  out  1  to `cordic_calc.enable`
- `cordic_x`, `cordic_y`  out  16  latched operands to CORDIC
- `cordic_mod`, `cordic_angle`  in  16  CORDIC results
- `out_valid`  out  1  one-cycle pulse; results valid
- `out_ch`  out  CHW  channel of current result
- `out_mod`  out  16  registered modulus, 6Q10
- `out_angle`  out  16  registered angle, 9Q7
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, LOAD, ITER, CAPT.
- IDLE:
  - If any `req` is high, pick the winner, pulse its `ack`, latch its x/y into `cordic_x`/`cordic_y`, record the index, and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: `cordic_start`=1 and `cordic_enable`=1 for one cycle; clear the iteration counter; go to ITER.
- ITER: `cordic_enable`=1, `cordic_start`=0. The counter counts 0..NITER-1. On terminal count go to CAPT.
- CAPT:
  - `cordic_enable`=0, which freezes the CORDIC registers.
  - Register `cordic_mod`→`out_mod`, `cordic_angle`→`out_angle`, and the index→`out_ch`.
  - Pulse `out_valid` on the next cycle; go to IDLE.
- Arbitration uses a round-robin pointer. Search starts at last-served+1 modulo NCH, and the pointer updates only on a grant.
- A channel whose `req` is still high after its `ack` is treated as a new request. It will not win again while another channel is requesting.
- `req` changes during LOAD/ITER/CAPT are ignored; a grant happens only in IDLE.
- `cordic_x`/`cordic_y` hold their values until the next grant.
- `out_*` hold their values between `out_valid` pulses.
- Reset values: all outputs 0, state IDLE, pointer 0 (channel 0 has first priority), counter 0.
- Reset mid-conversion aborts it: no `out_valid` is produced and `cordic_enable` drops immediately.
- `cordic_calc` keeps its own synchronous reset. It is driven from the same `reset` net at top level; this block does not drive it.

## Timing
- Grant at IDLE cycle T: `ack` high in T; `cordic_x`/`y` valid from T+1.
- `cordic_start` high in T+1 only.
- `cordic_enable` high from T+1 through T+1+NITER, i.e. NITER+1 cycles.
- CAPT is at T+2+NITER. `out_valid` pulses at T+3+NITER, which is also the next IDLE cycle.
- A new grant can occur in the same cycle as `out_valid`.
- Throughput is one conversion per NITER+3 cycles (19 with defaults).
- Worst-case wait for a continuously requesting channel is (NCH-1)·(NITER+3) cycles under round-robin.

## Configuration
- `CORDIC_SCHED_RR_EN` defined: round-robin arbitration as described above.
- `CORDIC_SCHED_RR_EN` undefined: fixed priority, lowest index wins. The pointer register is removed; all other timing is identical.

## Test plan
- Reset, then `req`=0001 with x=1024, y=0: `ack[0]` at T, `cordic_start` only at T+1, 17 cycles of `cordic_enable`, then `out_valid` at T+19 with `out_ch`=0 and `out_angle`=0 ±2.
- `req`=0100 with x=0, y=1024: `out_ch`=2, `out_angle`=11520 (90°) ±2. With x=-1024, y=0: `out_angle`=23040 (180°) ±2.
- All `req` held high for 8 conversions: grant order 0,1,2,3,0,1,2,3, with `out_valid` spaced exactly 19 cycles apart. Without the macro the order is 0,0,0,…
- Pulse `req[1]` during ITER of channel 3, then hold it: channel 1 is granted in the IDLE cycle coinciding with channel 3's `out_valid`. Toggling `x_in` of channel 3 mid-ITER leaves its result unchanged.
- Assert `reset` asynchronously mid-ITER: all outputs 0 within the same cycle, no `out_valid`; after release, `req`=1000 gets a normal grant and `out_ch`=3.

Source files
------------

// File: rtl/cordic_sched_if.sv
// cordic_sched_if: channel request/operand bus, CORDIC drive/result bus and result outputs of cordic_sched.
interface cordic_sched_if #(
    parameter int NCH = 4,
    parameter int CHW = 2
);
    logic [NCH-1:0]     req;
    logic [NCH-1:0]     ack;
    logic [16*NCH-1:0]  x_in;
    logic [16*NCH-1:0]  y_in;
    logic               cordic_start;
    logic               cordic_enable;
    logic [15:0]        cordic_x;
    logic [15:0]        cordic_y;
    logic [15:0]        cordic_mod;
    logic [15:0]        cordic_angle;
    logic               out_valid;
    logic [CHW-1:0]     out_ch;
    logic [15:0]        out_mod;
    logic [15:0]        out_angle;
    logic               busy;
    modport slave (
        input  req, x_in, y_in, cordic_mod, cordic_angle,
        output ack, cordic_start, cordic_enable, cordic_x, cordic_y,
               out_valid, out_ch, out_mod, out_angle, busy
    );
    modport master (
        output req, x_in, y_in, cordic_mod, cordic_angle,
        input  ack, cordic_start, cordic_enable, cordic_x, cordic_y,
               out_valid, out_ch, out_mod, out_angle, busy
    );
endinterface

// File: rtl/cordic_sched.sv
// cordic_sched: time-shares one CORDIC vectoring unit among NCH channels.
// CORDIC_SCHED_RR_EN selects round-robin arbitration; undefined gives fixed lowest-index priority.
module cordic_sched #(
    parameter int NCH   = 4,
    parameter int NITER = 16,
    parameter int CHW   = 2
) (
    input  logic          clock,
    input  logic          reset,
    cordic_sched_if.slave s
);
    localparam int CW = (NITER > 1) ? $clog2(NITER) : 1;
    typedef enum logic [1:0] {IDLE, LOAD, ITER, CAPT} state_t;
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CHW-1:0] ch_q, ch_d, och_q, och_d, base, win;
    logic [15:0]    x_q, x_d, y_q, y_d, mod_q, mod_d, ang_q, ang_d;
    logic           ov_q, ov_d, found;
    logic [CHW:0]   k;
`ifdef CORDIC_SCHED_RR_EN
    logic [CHW-1:0] ptr_q, ptr_d;
    assign base = ptr_q;
    always_comb ptr_d = (state_q == IDLE && found) ? ((win == CHW'(NCH - 1)) ? '0 : win + 1'b1) : ptr_q;
    always_ff @(posedge clock or posedge reset)
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
`else
    assign base = '0;
`endif
    // Scan offsets from highest to lowest so the nearest requester after base wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        k     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            k = {1'b0, base} + (CHW + 1)'(i);
            if (k >= (CHW + 1)'(NCH)) k = k - (CHW + 1)'(NCH);
            if (s.req[k[CHW-1:0]]) begin
                found = 1'b1;
                win   = k[CHW-1:0];
            end
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        x_d     = x_q;
        y_d     = y_q;
        mod_d   = mod_q;
        ang_d   = ang_q;
        och_d   = och_q;
        ov_d    = 1'b0;
        case (state_q)
            IDLE: if (found) begin
                state_d = LOAD;
                ch_d    = win;
                x_d     = s.x_in[{win, 4'd0} +: 16];
                y_d     = s.y_in[{win, 4'd0} +: 16];
            end
            LOAD: begin
                state_d = ITER;
                cnt_d   = '0;
            end
            ITER: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(NITER - 1)) ? CAPT : ITER;
            end
            CAPT: begin
                state_d = IDLE;
                mod_d   = s.cordic_mod;
                ang_d   = s.cordic_angle;
                och_d   = ch_q;
                ov_d    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            mod_q   <= '0;
            ang_q   <= '0;
            och_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mod_q   <= mod_d;
            ang_q   <= ang_d;
            och_q   <= och_d;
            ov_q    <= ov_d;
        end
    // ack is combinational from req so the grant is visible in the IDLE cycle that takes it.
    assign s.ack           = (state_q == IDLE && found && !reset) ? {{(NCH - 1){1'b0}}, 1'b1} << win : '0;
    assign s.cordic_start  = state_q == LOAD;
    assign s.cordic_enable = state_q == LOAD || state_q == ITER;
    assign s.cordic_x      = x_q;
    assign s.cordic_y      = y_q;
    assign s.out_valid     = ov_q;
    assign s.out_ch        = och_q;
    assign s.out_mod       = mod_q;
    assign s.out_angle     = ang_q;
    assign s.busy          = state_q != IDLE;
endmodule
